// File: rtl/pmips_pipe.sv
// pmips_pipe: five-stage (IF/ID/EX/MEM/WB) pipelined core with a
// parametrised datapath, register count and instruction width.
// It contains its own register file, ALU and control. It handles hazards in
// one of two ways. With FWD=1 it forwards results and stalls only on a
// load-use hazard. With FWD=0 it interlocks on every RAW hazard. Branches
// resolve in EX, and a taken branch flushes the two younger slots.
//
// Ports
//   clock      in   single clock, all state on the rising edge
//   reset      in   asynchronous, active-low
//   imemaddr   out  PC of the instruction being fetched
//   imemrdata  in   instruction at imemaddr (combinational)
//   dmemaddr   out  EX/MEM ALU result (load/store address)
//   dmemwdata  out  store data (forwarded rt value)
//   dmemwrite  out  store strobe in MEM
//   dmemread   out  load strobe in MEM
//   dmemrdata  in   load data at dmemaddr (combinational)
//   aluresult  out  EX-stage ALU output (debug)
//   stall      out  PC and IF/ID held this cycle
//   retire     out  a valid (non-bubble) instruction is in WB this cycle
//
// Instruction fields: opcode [IW-1:IW-4], rs, rt (RA bits each), and
// imm = the low IMMW bits. rd is the top RA bits of imm.
module pmips_pipe #(
    parameter int DW  = 16,
    parameter int RA  = 3,
    parameter int IW  = 17,
    parameter int FWD = 1
) (
    input  logic          clock,
    input  logic          reset,
    output logic [DW-1:0] imemaddr,
    input  logic [IW-1:0] imemrdata,
    output logic [DW-1:0] dmemaddr,
    output logic [DW-1:0] dmemwdata,
    output logic          dmemwrite,
    output logic          dmemread,
    input  logic [DW-1:0] dmemrdata,
    output logic [DW-1:0] aluresult,
    output logic          stall,
    output logic          retire
);

    localparam int NREG = 1 << RA;
    localparam int IMMW = IW - 4 - 2 * RA;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;

    // An all-zero stage register is a bubble: valid=0 and every control bit 0.
    typedef struct packed {
        logic          valid;
        logic [3:0]    op;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          alusrc;
        logic          beq;
        logic          bne;
        logic [RA-1:0] rs;
        logic [RA-1:0] rt;
        logic [RA-1:0] dest;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [DW-1:0] pcplus;
    } idex_t;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic [RA-1:0] dest;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
    } exmem_t;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic [RA-1:0] dest;
        logic [DW-1:0] data;
    } memwb_t;

    // ---------------- state ----------------
    logic [DW-1:0] r_pc;
    logic          r_ifid_valid;
    logic [IW-1:0] r_ifid_instr;
    logic [DW-1:0] r_ifid_pcplus;
    idex_t         r_idex;
    exmem_t        r_exmem;
    memwb_t        r_memwb;
    logic [DW-1:0] r_rf [NREG];

    // ---------------- wires ----------------
    logic [DW-1:0]   w_pcplus;
    logic [3:0]      w_op;
    logic [RA-1:0]   w_rs;
    logic [RA-1:0]   w_rt;
    logic [RA-1:0]   w_rd;
    logic [IMMW-1:0] w_imm;
    logic [DW-1:0]   w_imm_sext;
    logic            w_regwrite;
    logic            w_memread;
    logic            w_memwrite;
    logic            w_alusrc;
    logic            w_beq;
    logic            w_bne;
    logic            w_uses_rs;
    logic            w_uses_rt;
    logic [RA-1:0]   w_dest;
    logic [DW-1:0]   w_rs_val;
    logic [DW-1:0]   w_rt_val;
    logic            w_wb_we;
    idex_t           w_idex_next;
    logic [DW-1:0]   w_op_a;
    logic [DW-1:0]   w_op_b;
    logic [DW-1:0]   w_alu_b;
    logic [DW-1:0]   w_alu;
    logic            w_taken;
    logic [DW-1:0]   w_target;
    logic            w_hazard;
    logic [DW-1:0]   w_mem_data;

    // ---------------- IF ----------------
    assign w_pcplus = r_pc + DW'(2);

    // ---------------- ID ----------------
    assign w_op       = r_ifid_instr[IW-1 -: 4];
    assign w_rs       = r_ifid_instr[IW-5 -: RA];
    assign w_rt       = r_ifid_instr[IW-5-RA -: RA];
    assign w_imm      = r_ifid_instr[IMMW-1:0];
    assign w_rd       = w_imm[IMMW-1 -: RA];
    assign w_imm_sext = {{(DW-IMMW){w_imm[IMMW-1]}}, w_imm};

    always_comb begin
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_beq      = 1'b0;
        w_bne      = 1'b0;
        w_uses_rs  = 1'b0;
        w_uses_rt  = 1'b0;
        w_dest     = w_rt;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                w_regwrite = 1'b1;
                w_uses_rs  = 1'b1;
                w_uses_rt  = 1'b1;
                w_dest     = w_rd;
            end
            OP_ADDI: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_uses_rs  = 1'b1;
            end
            OP_LW: begin
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_alusrc   = 1'b1;
                w_uses_rs  = 1'b1;
            end
            OP_SW: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_uses_rs  = 1'b1;
                w_uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                w_beq     = 1'b1;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_BNE: begin
                w_bne     = 1'b1;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file read with a write-through bypass from WB.
    // r0 is never written, so reading r_rf[0] always gives 0.
    assign w_wb_we  = r_memwb.regwrite && (r_memwb.dest != '0);
    assign w_rs_val = (w_wb_we && r_memwb.dest == w_rs) ? r_memwb.data : r_rf[w_rs];
    assign w_rt_val = (w_wb_we && r_memwb.dest == w_rt) ? r_memwb.data : r_rf[w_rt];

    always_comb begin
        w_idex_next          = '0;
        w_idex_next.valid    = r_ifid_valid;
        w_idex_next.op       = w_op;
        w_idex_next.regwrite = w_regwrite;
        w_idex_next.memread  = w_memread;
        w_idex_next.memwrite = w_memwrite;
        w_idex_next.alusrc   = w_alusrc;
        w_idex_next.beq      = w_beq;
        w_idex_next.bne      = w_bne;
        w_idex_next.rs       = w_rs;
        w_idex_next.rt       = w_rt;
        w_idex_next.dest     = w_dest;
        w_idex_next.rs_val   = w_rs_val;
        w_idex_next.rt_val   = w_rt_val;
        w_idex_next.imm      = w_imm_sext;
        w_idex_next.pcplus   = r_ifid_pcplus;
    end

    // Hazard detection. With forwarding, only a load in EX that feeds the ID
    // instruction must wait one cycle. Without forwarding, any producer still
    // in EX or MEM blocks the consumer. A producer in WB is covered by the
    // register-file bypass.
    always_comb begin
        w_hazard = 1'b0;
        if (FWD != 0) begin
            if (r_idex.memread && r_idex.dest != '0 &&
                (r_idex.dest == w_rs || r_idex.dest == w_rt))
                w_hazard = 1'b1;
        end else begin
            if (r_idex.regwrite && r_idex.dest != '0 &&
                ((w_uses_rs && r_idex.dest == w_rs) || (w_uses_rt && r_idex.dest == w_rt)))
                w_hazard = 1'b1;
            if (r_exmem.regwrite && r_exmem.dest != '0 &&
                ((w_uses_rs && r_exmem.dest == w_rs) || (w_uses_rt && r_exmem.dest == w_rt)))
                w_hazard = 1'b1;
        end
        w_hazard = w_hazard && r_ifid_valid;
    end

    // ---------------- EX ----------------
    // Forwarding priority: EX/MEM first, then MEM/WB. A load still in EX/MEM
    // has no data yet and is never a forwarding source.
    always_comb begin
        w_op_a = r_idex.rs_val;
        w_op_b = r_idex.rt_val;
        if (FWD != 0) begin
            if (r_exmem.regwrite && !r_exmem.memread && r_exmem.dest != '0 &&
                r_exmem.dest == r_idex.rs)
                w_op_a = r_exmem.alu;
            else if (r_memwb.regwrite && r_memwb.dest != '0 && r_memwb.dest == r_idex.rs)
                w_op_a = r_memwb.data;
            if (r_exmem.regwrite && !r_exmem.memread && r_exmem.dest != '0 &&
                r_exmem.dest == r_idex.rt)
                w_op_b = r_exmem.alu;
            else if (r_memwb.regwrite && r_memwb.dest != '0 && r_memwb.dest == r_idex.rt)
                w_op_b = r_memwb.data;
        end
    end

    assign w_alu_b = r_idex.alusrc ? r_idex.imm : w_op_b;

    always_comb begin
        case (r_idex.op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: w_alu = w_op_a + w_alu_b;
            OP_AND:                        w_alu = w_op_a & w_alu_b;
            OP_OR:                         w_alu = w_op_a | w_alu_b;
            OP_SLT:  w_alu = {{(DW-1){1'b0}}, ($signed(w_op_a) < $signed(w_alu_b))};
            default:                       w_alu = w_op_a - w_alu_b;
        endcase
    end

    assign w_taken  = r_idex.valid &&
                      ((r_idex.beq && w_op_a == w_op_b) || (r_idex.bne && w_op_a != w_op_b));
    assign w_target = r_idex.pcplus + (r_idex.imm << 1);

    // ---------------- MEM ----------------
    assign w_mem_data = r_exmem.memread ? dmemrdata : r_exmem.alu;

    // ---------------- sequential ----------------
    // A taken branch wins over a stall. The stalled ID instruction lies on
    // the wrong path and is squashed along with the fetch slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= '0;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= '0;
            r_ifid_pcplus <= '0;
        end else if (w_taken) begin
            r_pc          <= w_target;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= '0;
            r_ifid_pcplus <= '0;
        end else if (!w_hazard) begin
            r_pc          <= w_pcplus;
            r_ifid_valid  <= 1'b1;
            r_ifid_instr  <= imemrdata;
            r_ifid_pcplus <= w_pcplus;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_idex <= '0;
        else if (w_taken || w_hazard)
            r_idex <= '0;
        else
            r_idex <= w_idex_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_exmem <= '0;
        end else begin
            r_exmem.valid    <= r_idex.valid;
            r_exmem.regwrite <= r_idex.regwrite;
            r_exmem.memread  <= r_idex.memread;
            r_exmem.memwrite <= r_idex.memwrite;
            r_exmem.dest     <= r_idex.dest;
            r_exmem.alu      <= w_alu;
            r_exmem.wdata    <= w_op_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_memwb <= '0;
        end else begin
            r_memwb.valid    <= r_exmem.valid;
            r_memwb.regwrite <= r_exmem.regwrite;
            r_memwb.dest     <= r_exmem.dest;
            r_memwb.data     <= w_mem_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_wb_we) begin
            r_rf[r_memwb.dest] <= r_memwb.data;
        end
    end

    // ---------------- outputs ----------------
    assign imemaddr  = r_pc;
    assign dmemaddr  = r_exmem.alu;
    assign dmemwdata = r_exmem.wdata;
    assign dmemwrite = r_exmem.memwrite;
    assign dmemread  = r_exmem.memread;
    assign aluresult = w_alu;
    assign stall     = w_hazard && !w_taken;
    assign retire    = r_memwb.valid;

endmodule

// File: tb/tb_pmips_pipe.sv
// Bench for pmips_pipe. Two cores run the same programs side by side: one
// with forwarding (FWD=1) and one with full interlock (FWD=0). Each has its
// own data memory. Every store is an observable result. Expected stores are
// queued when a program is loaded, and a monitor pops and compares them
// whenever a core strobes dmemwrite. Stall, retire and fetch-address timing
// is recorded per cycle and compared against hand-derived values.
module tb_pmips_pipe;

    localparam int DW = 16;
    localparam int IW = 17;
    localparam int NC = 40;
    localparam logic [IW-1:0] NOP = 17'h1E000;

    logic clock;
    logic reset;

    logic [DW-1:0] imemaddr1, dmemaddr1, dmemwdata1, dmemrdata1, aluresult1;
    logic [IW-1:0] imemrdata1;
    logic          dmemwrite1, dmemread1, stall1, retire1;
    logic [DW-1:0] imemaddr0, dmemaddr0, dmemwdata0, dmemrdata0, aluresult0;
    logic [IW-1:0] imemrdata0;
    logic          dmemwrite0, dmemread0, stall0, retire0;

    logic [IW-1:0] imem  [0:63];
    logic [DW-1:0] dmem1 [0:63];
    logic [DW-1:0] dmem0 [0:63];

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];

    int n_checks;
    int n_pass;

    logic          ret1 [0:NC-1];
    logic          ret0 [0:NC-1];
    logic          stl1 [0:NC-1];
    logic          stl0 [0:NC-1];
    logic [DW-1:0] ia1  [0:NC-1];
    logic [DW-1:0] ia0  [0:NC-1];
    int nstall1;
    int nstall0;

    // ---------------- DUTs ----------------
    pmips_pipe #(.DW(16), .RA(3), .IW(17), .FWD(1)) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .imemaddr  (imemaddr1),
        .imemrdata (imemrdata1),
        .dmemaddr  (dmemaddr1),
        .dmemwdata (dmemwdata1),
        .dmemwrite (dmemwrite1),
        .dmemread  (dmemread1),
        .dmemrdata (dmemrdata1),
        .aluresult (aluresult1),
        .stall     (stall1),
        .retire    (retire1)
    );

    pmips_pipe #(.DW(16), .RA(3), .IW(17), .FWD(0)) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .imemaddr  (imemaddr0),
        .imemrdata (imemrdata0),
        .dmemaddr  (dmemaddr0),
        .dmemwdata (dmemwdata0),
        .dmemwrite (dmemwrite0),
        .dmemread  (dmemread0),
        .dmemrdata (dmemrdata0),
        .aluresult (aluresult0),
        .stall     (stall0),
        .retire    (retire0)
    );

    // ---------------- clock and memories ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imemrdata1 = imem[imemaddr1[6:1]];
    assign imemrdata0 = imem[imemaddr0[6:1]];
    assign dmemrdata1 = dmem1[dmemaddr1[6:1]];
    assign dmemrdata0 = dmem0[dmemaddr0[6:1]];

    always @(posedge clock) begin
        if (dmemwrite1) dmem1[dmemaddr1[6:1]] <= dmemwdata1;
        if (dmemwrite0) dmem0[dmemaddr0[6:1]] <= dmemwdata0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [IW-1:0] rtyp(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [2:0] rt);
        return {op, rs, rt, rd, 4'b0000};
    endfunction

    task automatic push_store(input logic [15:0] addr, input logic [15:0] data);
        exp_q1.push_back({addr, data});
        exp_q0.push_back({addr, data});
    endtask

    task automatic start_prog();
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Cycle k is sampled 1 time unit after the k-th falling edge following release.
    task automatic run(input int n);
        nstall1 = 0;
        nstall0 = 0;
        for (int k = 0; k < n; k++) begin
            #1;
            ret1[k] = retire1;
            ret0[k] = retire0;
            stl1[k] = stall1;
            stl0[k] = stall0;
            ia1[k]  = imemaddr1;
            ia0[k]  = imemaddr0;
            if (stall1) nstall1++;
            if (stall0) nstall0++;
            @(negedge clock);
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_q1_left"}, exp_q1.size(), 0);
        check({tag, "_q0_left"}, exp_q0.size(), 0);
        exp_q1.delete();
        exp_q0.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset && dmemwrite1) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                $display("FAIL fwd1_store: unexpected store addr %0h data %0h", dmemaddr1, dmemwdata1);
            end else begin
                check("fwd1_store", {dmemaddr1, dmemwdata1}, exp_q1.pop_front());
            end
        end
        if (reset && dmemwrite0) begin
            if (exp_q0.size() == 0) begin
                n_checks++;
                $display("FAIL fwd0_store: unexpected store addr %0h data %0h", dmemaddr0, dmemwdata0);
            end else begin
                check("fwd0_store", {dmemaddr0, dmemwdata0}, exp_q0.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [8:0] exp_r1;
    logic [8:0] exp_r0;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        #3 reset = 1'b0;
        #1;
        check("rst_imemaddr", 32'(imemaddr1), 0);
        check("rst_dmemwrite", 32'(dmemwrite1), 0);
        check("rst_retire", 32'(retire1), 0);
        check("rst_stall", 32'(stall1), 0);
        check("rst_aluresult", 32'(aluresult1), 0);
        check("rst_dmemaddr", 32'(dmemaddr1), 0);

        // S1: ALU with back-to-back dependents. FWD=1 runs without stalls;
        // FWD=0 stalls 2 cycles before the ADD.
        start_prog();
        imem[0] = enc(4'd5, 3'd0, 3'd1, 7'd5);
        imem[1] = enc(4'd5, 3'd0, 3'd2, 7'd3);
        imem[2] = rtyp(4'd0, 3'd3, 3'd1, 3'd2);
        imem[3] = rtyp(4'd1, 3'd4, 3'd1, 3'd2);
        imem[5] = enc(4'd7, 3'd0, 3'd3, 7'h10);
        imem[6] = enc(4'd7, 3'd0, 3'd4, 7'h12);
        push_store(16'h0010, 16'd8);
        push_store(16'h0012, 16'd2);
        release_reset();
        run(NC);
        exp_r1 = 9'b111110000;
        exp_r0 = 9'b100110000;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("s1_ret1_c%0d", k), 32'(ret1[k]), 32'(exp_r1[k]));
            check($sformatf("s1_ret0_c%0d", k), 32'(ret0[k]), 32'(exp_r0[k]));
        end
        check("s1_ia1_c0", 32'(ia1[0]), 0);
        check("s1_ia1_c1", 32'(ia1[1]), 2);
        check("s1_nstall1", nstall1, 0);
        check("s1_nstall0", nstall0, 2);
        check("s1_stl0_c3", 32'(stl0[3]), 1);
        check("s1_stl0_c4", 32'(stl0[4]), 1);
        check_drained("s1");

        // S2: load-use. A single stall cycle with FWD=1, and r6 = 16.
        start_prog();
        imem[0] = enc(4'd5, 3'd0, 3'd3, 7'd8);
        imem[1] = enc(4'd7, 3'd0, 3'd3, 7'h10);
        imem[2] = enc(4'd6, 3'd0, 3'd5, 7'h10);
        imem[3] = rtyp(4'd0, 3'd6, 3'd5, 3'd5);
        imem[4] = enc(4'd7, 3'd0, 3'd6, 7'h14);
        push_store(16'h0010, 16'd8);
        push_store(16'h0014, 16'd16);
        release_reset();
        run(NC);
        check("s2_nstall1", nstall1, 1);
        check("s2_stl1_c4", 32'(stl1[4]), 1);
        check("s2_stl1_c3", 32'(stl1[3]), 0);
        check_drained("s2");

        // S3: taken BEQ at PC 6 with offset +2. Both ADDIs are squashed and
        // the fetch moves to 12.
        start_prog();
        imem[0] = enc(4'd5, 3'd0, 3'd1, 7'd5);
        imem[3] = enc(4'd8, 3'd1, 3'd1, 7'd2);
        imem[4] = enc(4'd5, 3'd0, 3'd2, 7'd7);
        imem[5] = enc(4'd5, 3'd0, 3'd3, 7'd9);
        imem[6] = enc(4'd7, 3'd0, 3'd1, 7'h20);
        imem[7] = enc(4'd7, 3'd0, 3'd2, 7'h22);
        imem[8] = enc(4'd7, 3'd0, 3'd3, 7'h24);
        push_store(16'h0020, 16'd5);
        push_store(16'h0022, 16'd0);
        push_store(16'h0024, 16'd0);
        release_reset();
        run(NC);
        check("s3_ia1_c5", 32'(ia1[5]), 10);
        check("s3_ia1_c6", 32'(ia1[6]), 12);
        check("s3_ia0_c6", 32'(ia0[6]), 12);
        check("s3_ret1_c7", 32'(ret1[7]), 1);
        check("s3_ret1_c8", 32'(ret1[8]), 0);
        check("s3_ret1_c9", 32'(ret1[9]), 0);
        check("s3_ret1_c10", 32'(ret1[10]), 1);
        check("s3_ret0_c8", 32'(ret0[8]), 0);
        check("s3_nstall1", nstall1, 0);
        check("s3_nstall0", nstall0, 0);
        check_drained("s3");

        // S4: BNE r1,r1 is not taken, so there is no flush and no lost cycle.
        start_prog();
        imem[0] = enc(4'd5, 3'd0, 3'd1, 7'd5);
        imem[3] = enc(4'd9, 3'd1, 3'd1, 7'd3);
        imem[4] = enc(4'd5, 3'd0, 3'd2, 7'd7);
        imem[5] = enc(4'd5, 3'd0, 3'd3, 7'd9);
        imem[6] = enc(4'd7, 3'd0, 3'd2, 7'h22);
        imem[7] = enc(4'd7, 3'd0, 3'd3, 7'h24);
        push_store(16'h0022, 16'd7);
        push_store(16'h0024, 16'd9);
        release_reset();
        run(NC);
        check("s4_ia1_c6", 32'(ia1[6]), 12);
        for (int k = 4; k < 12; k++)
            check($sformatf("s4_ret1_c%0d", k), 32'(ret1[k]), 1);
        check("s4_nstall1", nstall1, 0);
        check_drained("s4");

        // S5: AND/OR/signed SLT and a discarded write to r0.
        start_prog();
        imem[0]  = enc(4'd5, 3'd0, 3'd1, 7'd5);
        imem[1]  = enc(4'd5, 3'd0, 3'd2, 7'd3);
        imem[2]  = rtyp(4'd2, 3'd3, 3'd1, 3'd2);
        imem[3]  = rtyp(4'd3, 3'd4, 3'd1, 3'd2);
        imem[4]  = rtyp(4'd4, 3'd5, 3'd2, 3'd1);
        imem[5]  = enc(4'd5, 3'd0, 3'd6, 7'h7F);
        imem[6]  = rtyp(4'd4, 3'd7, 3'd6, 3'd1);
        imem[7]  = rtyp(4'd4, 3'd6, 3'd1, 3'd2);
        imem[8]  = enc(4'd5, 3'd1, 3'd0, 7'd1);
        imem[9]  = enc(4'd7, 3'd0, 3'd0, 7'h2A);
        imem[10] = enc(4'd7, 3'd0, 3'd3, 7'h20);
        imem[11] = enc(4'd7, 3'd0, 3'd4, 7'h22);
        imem[12] = enc(4'd7, 3'd0, 3'd5, 7'h24);
        imem[13] = enc(4'd7, 3'd0, 3'd7, 7'h26);
        imem[14] = enc(4'd7, 3'd0, 3'd6, 7'h28);
        push_store(16'h002A, 16'd0);
        push_store(16'h0020, 16'd1);
        push_store(16'h0022, 16'd7);
        push_store(16'h0024, 16'd1);
        push_store(16'h0026, 16'd1);
        push_store(16'h0028, 16'd0);
        release_reset();
        run(NC);
        check_drained("s5");

        // S6: asynchronous reset between edges while a store sits in MEM,
        // then re-execution from address 0.
        start_prog();
        imem[0] = enc(4'd5, 3'd0, 3'd1, 7'd5);
        imem[3] = enc(4'd7, 3'd0, 3'd1, 7'h30);
        imem[4] = enc(4'd7, 3'd0, 3'd1, 7'h32);
        imem[5] = enc(4'd7, 3'd0, 3'd1, 7'h34);
        push_store(16'h0030, 16'd5);
        push_store(16'h0032, 16'd5);
        release_reset();
        for (int k = 0; k < 7; k++) @(negedge clock);
        #1;
        check("s6_pre_dmemwrite", 32'(dmemwrite1), 1);
        check("s6_pre_imemaddr", 32'(imemaddr1), 14);
        #1 reset = 1'b0;
        #1;
        check("s6_rst_imemaddr1", 32'(imemaddr1), 0);
        check("s6_rst_dmemwrite1", 32'(dmemwrite1), 0);
        check("s6_rst_retire1", 32'(retire1), 0);
        check("s6_rst_imemaddr0", 32'(imemaddr0), 0);
        check("s6_rst_dmemwrite0", 32'(dmemwrite0), 0);
        check("s6_rst_retire0", 32'(retire0), 0);
        check_drained("s6a");
        @(negedge clock);
        push_store(16'h0030, 16'd5);
        push_store(16'h0032, 16'd5);
        push_store(16'h0034, 16'd5);
        release_reset();
        run(NC);
        check("s6_ia1_c0", 32'(ia1[0]), 0);
        check("s6_ia1_c1", 32'(ia1[1]), 2);
        check("s6_ret1_c3", 32'(ret1[3]), 0);
        check("s6_ret1_c4", 32'(ret1[4]), 1);
        check_drained("s6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pmips_pipe.md
# pmips_pipe

Parametrised successor to the 16-bit, 17-bit-instruction five-stage pipelined core: IF/ID/EX/MEM/WB with data width, register count and instruction width set by parameters. Adds hazard handling: forwarding or full interlock, selected by parameter; load-use stall; and branch flush with a resolved-taken redirect. It sits between the instruction memory and the data memory and contains its own register file, ALU and control.

## Interface
- DW, 16: datapath and address width.
- RA, 3: register address bits; NREG = 2^RA registers, r0 hardwired to 0.
- IW, 17: instruction width. Fields: opcode [IW-1:IW-4], rs [IW-5:IW-4-RA], rt next RA bits, imm = low IMMW = IW-4-2*RA bits, rd = top RA bits of imm. Requires IMMW ≥ RA+1.
- FWD, 1: 1 = forwarding plus load-use stall; 0 = no forwarding, interlock on every RAW hazard.
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- imemaddr  out  DW  PC of the fetched instruction.
- imemrdata  in  IW  instruction at imemaddr, combinational same cycle.
- dmemaddr  out  DW  EX/MEM ALU result.
- dmemwdata  out  DW  store data, forwarded value.
- dmemwrite  out  1  store strobe in MEM.
- dmemread  out  1  load strobe in MEM.
- dmemrdata  in  DW  load data, combinational on dmemaddr.
- aluresult  out  DW  EX-stage ALU output, for debug.
- stall  out  1  PC and IF/ID held this cycle.
- retire  out  1  a valid non-bubble instruction is in WB this cycle.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed; rd = 1/0). 5 ADDI rt = rs + sext(imm). 6 LW rt = mem[rs + sext(imm)]. 7 SW mem[rs + sext(imm)] = rt. 8 BEQ. 9 BNE. 10-15 NOP. All arithmetic is mod 2^DW.
- R-type opcodes (0-4) write rd. ADDI and LW write rt. Writes to r0 are discarded.
- Branch target = PCplus + (sext(imm) << 1), where PCplus = PC + 2. Branches are resolved in EX.
- Taken branch: PC loads the target at the next edge. IF/ID and ID/EX become bubbles, giving a 2-cycle penalty. A not-taken branch has no penalty.
- Register file writes in WB. An ID read of the same register in the same cycle returns the WB data (internal bypass).
- FWD=1, EX operand select per source: EX/MEM match wins, then MEM/WB match, then the ID/EX value. A match requires a nonzero register and RegWrite set. An EX/MEM load result is never forwarded from EX/MEM.
- FWD=1 load-use: ID/EX holds a LW, its rt is nonzero and equals the IF/ID rs or rt. Then stall=1 for 1 cycle: PC and IF/ID hold, and a bubble enters ID/EX.
- FWD=0: stall while any valid instruction in ID/EX or EX/MEM writes a nonzero register read by the IF/ID instruction. The MEM/WB case is covered by the bypass.
- Taken branch together with stall: the flush has priority. The stalled IF/ID instruction is squashed and the PC takes the target.
- A bubble has all control signals 0 and valid=0.

## Timing
- Reset asserted (low), asynchronously: PC=0 and every pipeline register becomes a bubble or zero. All outputs are 0, imemaddr=0, and the register file is cleared to 0.
- Reset released: the instruction at address 0 is fetched in cycle 0. With no hazards it is in WB in cycle 4 (retire=1) and written at the end of cycle 4.
- Throughput is 1 instruction per cycle without hazards.
- Stall lengths: load-use stalls 1 cycle. FWD=0 dependency stalls 2 cycles when the producer is adjacent, 1 cycle when it is 2 instructions apart.
- Reset asserted mid-operation aborts everything in flight. No MEM write occurs in the reset cycle.
- PC wraps modulo 2^DW.

## Test plan
- Reset and ALU: preload via ADDI r1=5, r2=3; then ADD r3=r1,r2 and SUB r4=r1,r2 back-to-back (FWD=1). Expect r3=8, r4=2, no stall, 4 retires in 4 consecutive cycles starting cycle 4.
- Load-use: SW r3→[0x10], LW r5=[0x10], ADD r6=r5,r5. Expect stall=1 for exactly 1 cycle and r6=16.
- Taken branch: BEQ r1,r1,+2 followed by 2 ADDI. Expect both ADDIs squashed (no retire, registers unchanged) and the next imemaddr equal to PC+2+4.
- Not-taken: BNE r1,r1. Expect no flush and no extra cycles.
- FWD=0: same sequence as the ALU scenario. Expect identical register results and 2 stall cycles before ADD; the SUB adds no further stall.
- Async reset: pull reset low mid-stream between edges. Expect immediate PC=0, dmemwrite=0 and retire=0. After release, re-execution from address 0.
